// File: rtl/add_float64_sigs.sv
// rtl/add_float64_sigs.sv - same-sign binary64 significand add behind an ap_ctrl_hs handshake
// Operands are captured on accept; ALIGN, ADD and ROUND each take one cycle before the DONE pulse.
module add_float64_sigs (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        zSign,
  output logic [63:0] ap_return
);
  localparam logic [63:0] IMPLICIT_BIT = 64'h2000000000000000;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ALIGN = 5'b00010,
    ADD   = 5'b00100,
    ROUND = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t      state;
  logic [63:0] a_q, b_q;
  logic        z_sign_q;
  logic        bypass_q, skip_add_q;
  logic [63:0] bypass_val_q, big_sig_q, small_sig_q, z_sig_q;
  logic [12:0] z_exp_q;

  function automatic logic [63:0] special_result(input logic [63:0] x, input logic [63:0] y);
    logic x_nan, y_nan;
    x_nan = (x[62:52] == 11'h7FF) && (x[51:0] != 52'h0);
    y_nan = (y[62:52] == 11'h7FF) && (y[51:0] != 52'h0);
    if (x_nan)                     return x | 64'h0008000000000000;
    else if (y_nan)                return y | 64'h0008000000000000;
    else if (x[62:52] == 11'h7FF)  return x;
    else                           return y;
  endfunction

  // Sticky right shift: anything shifted out is OR-ed into bit 0.
  function automatic logic [63:0] shift_right_jam(input logic [63:0] sig, input logic [11:0] count);
    logic [63:0] lost_mask;
    if (count == 12'd0)  return sig;
    if (count >= 12'd64) return {63'b0, |sig};
    lost_mask = ~(~64'h0 << count[5:0]);
    return (sig >> count[5:0]) | {63'b0, |(sig & lost_mask)};
  endfunction

  logic [10:0] a_exp, b_exp, big_exp, small_exp;
  logic [63:0] a_sig, b_sig, big_sig_raw, small_sig_raw;
  logic [11:0] exp_diff, exp_diff_abs, shift_count;
  logic        a_is_big;

  assign a_exp        = a_q[62:52];
  assign b_exp        = b_q[62:52];
  assign a_sig        = {3'b0, a_q[51:0], 9'b0};
  assign b_sig        = {3'b0, b_q[51:0], 9'b0};
  assign exp_diff     = {1'b0, a_exp} - {1'b0, b_exp};
  assign a_is_big     = !exp_diff[11];
  assign exp_diff_abs = exp_diff[11] ? (12'd0 - exp_diff) : exp_diff;
  assign big_exp       = a_is_big ? a_exp : b_exp;
  assign small_exp     = a_is_big ? b_exp : a_exp;
  assign big_sig_raw   = a_is_big ? a_sig : b_sig;
  assign small_sig_raw = a_is_big ? b_sig : a_sig;
  assign shift_count   = exp_diff_abs - {11'b0, small_exp == 11'h0};

  logic        al_bypass, al_skip_add;
  logic [63:0] al_bypass_val, al_small_sig, al_zsig;
  logic [12:0] al_zexp;

  always_comb begin
    al_bypass     = 1'b0;
    al_skip_add   = 1'b0;
    al_bypass_val = 64'h0;
    al_small_sig  = 64'h0;
    al_zsig       = 64'h0;
    al_zexp       = {2'b0, big_exp};
    if (exp_diff == 12'd0) begin
      if (a_exp == 11'h7FF) begin
        al_bypass     = 1'b1;
        al_bypass_val = special_result(a_q, b_q);
      end else if (a_exp == 11'h0) begin
        // Subnormal pair: a carry out of the fraction lands in the exponent field on its own.
        al_bypass     = 1'b1;
        al_bypass_val = {z_sign_q, 63'b0} + ((a_sig + b_sig) >> 9);
      end else begin
        al_skip_add = 1'b1;
        al_zsig     = 64'h4000000000000000 + a_sig + b_sig;
      end
    end else if (big_exp == 11'h7FF) begin
      al_bypass     = 1'b1;
      al_bypass_val = special_result(a_q, b_q);
    end else begin
      al_small_sig = shift_right_jam((small_exp == 11'h0) ? small_sig_raw
                                                          : (small_sig_raw | IMPLICIT_BIT),
                                     shift_count);
    end
  end

  logic [63:0] add_sum, add_zsig;
  logic [12:0] add_zexp;

  assign add_sum  = (big_sig_q | IMPLICIT_BIT) + small_sig_q;
  assign add_zsig = add_sum[62] ? add_sum : (add_sum << 1);
  assign add_zexp = add_sum[62] ? z_exp_q : (z_exp_q - 13'd1);

  logic [63:0] rnd_inc, rnd_sig, rnd_result;
  logic [12:0] rnd_exp;
  logic        rnd_overflow;

  assign rnd_inc      = z_sig_q + 64'h200;
  assign rnd_overflow = (z_exp_q > 13'h7FD) || ((z_exp_q == 13'h7FD) && rnd_inc[63]);
  assign rnd_sig      = (rnd_inc >> 10) & ~{63'b0, z_sig_q[9:0] == 10'h200};
  assign rnd_exp      = (rnd_sig == 64'h0) ? 13'h0 : z_exp_q;

  always_comb begin
    rnd_result = 64'h0;
    if (bypass_q)          rnd_result = bypass_val_q;
    else if (rnd_overflow) rnd_result = {z_sign_q, 11'h7FF, 52'h0};
    else                   rnd_result = {z_sign_q, 63'b0} + {rnd_exp[11:0], 52'h0} + rnd_sig;
  end

  assign ap_idle  = (state == IDLE) && !ap_start;
  assign ap_ready = ap_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      ap_done   <= 1'b0;
      ap_return <= 64'h0;
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        IDLE: if (ap_start) begin
          a_q      <= a;
          b_q      <= b;
          z_sign_q <= zSign;
          state    <= ALIGN;
        end
        ALIGN: begin
          bypass_q     <= al_bypass;
          bypass_val_q <= al_bypass_val;
          skip_add_q   <= al_skip_add;
          big_sig_q    <= big_sig_raw;
          small_sig_q  <= al_small_sig;
          z_sig_q      <= al_zsig;
          z_exp_q      <= al_zexp;
          state        <= ADD;
        end
        ADD: begin
          if (!bypass_q && !skip_add_q) begin
            z_sig_q <= add_zsig;
            z_exp_q <= add_zexp;
          end
          state <= ROUND;
        end
        ROUND: begin
          ap_return <= rnd_result;
          ap_done   <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/add_float64_sigs.md
ADD_FLOAT64_SIGS -- requirements
Module: add_float64_sigs

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 ap_clk  in  1  clock, all state on rising edge.
REQ-003 ap_rst  in  1  synchronous active-high reset.
REQ-004 ap_start  in  1  request; sampled only in IDLE.
REQ-005 ap_done  out  1  one-cycle pulse, result valid.
REQ-006 ap_idle  out  1  high when in IDLE and ap_start=0.
REQ-007 ap_ready  out  1  one-cycle pulse, identical to ap_done.
REQ-008 a  in  64  IEEE-754 binary64 operand A.
REQ-009 b  in  64  IEEE-754 binary64 operand B, same sign as A by contract.
REQ-010 zSign  in  1  sign of result.
REQ-011 ap_return  out  64  registered binary64 sum.

Function
REQ-012 SHALL implement an ap_ctrl_hs responder with states IDLE, ALIGN, ADD, ROUND, DONE, one-hot encoded.
REQ-013 SHALL, in IDLE with ap_start=1, capture a, b, zSign into internal registers and go to ALIGN; otherwise stay in IDLE.
REQ-014 SHALL advance ALIGN->ADD->ROUND->DONE->IDLE unconditionally, one state per cycle; ap_done/ap_ready high only in DONE, exactly 4 cycles after the accept cycle.
REQ-015 SHALL ignore ap_start outside IDLE; minimum start-to-start interval 5 cycles; ap_start held high restarts on the IDLE cycle after DONE.
REQ-016 SHALL decode exp = bits[62:52] (11b), sig = bits[51:0] pre-shifted left 9 into a 64b field; expDiff = aExp - bExp (signed 12b).
REQ-017 ALIGN: larger-exponent operand gets exponent 0x7FF -> special path; otherwise smaller operand gets implicit bit 0x2000000000000000 if its exp != 0, else expDiff decremented by 1; smaller sig shifted right by |expDiff| with jamming (any shifted-out 1 sets bit 0; shift >= 63 yields 1 if sig != 0 else 0); zExp = larger exponent.
REQ-018 ALIGN, expDiff = 0: exp 0x7FF -> special path; exp 0 -> result = {zSign, 11'h0, (aSig+bSig)>>9} (carry into exponent field by addition), skip rounding; otherwise zSig = 0x4000000000000000 + aSig + bSig, zExp = aExp, go straight to rounding.
REQ-019 ADD (expDiff != 0): larger sig ORed with 0x2000000000000000; zSig = (aSig+bSig)<<1, zExp decremented; if bit 63 of zSig set, zSig = aSig+bSig and zExp incremented back.
REQ-020 ROUND: round-to-nearest-even; roundBits = zSig[9:0]; if zExp > 0x7FD, or zExp = 0x7FD and zSig+0x200 overflows bit 63, result = {zSign, 0x7FF, 52'h0}.
REQ-021 ROUND otherwise: zSig = (zSig+0x200)>>10; clear bit 0 if roundBits = 0x200; zExp = 0 if zSig = 0; result = (zSign<<63) + (zExp<<52) + zSig, 64b modular addition.
REQ-022 Special path: any NaN operand -> return that NaN with bit 51 set, A preferred when both NaN; else infinity -> return A's pattern if A is infinite, else B's.
REQ-023 zExp SHALL be carried as 13b unsigned; the same-sign contract never makes it negative, so there is no underflow path.
REQ-024 ap_return SHALL update only on the ROUND->DONE transition and hold until the next such transition.
REQ-025 SHALL raise no exception flags and ignore operand signs; only zSign drives the result sign.

Reset
REQ-026 ap_rst=1 at any edge SHALL force IDLE, ap_done=0, ap_ready=0, ap_return=64'h0; ap_idle=1 next cycle if ap_start=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no ap_done pulse; a start in the first post-reset cycle SHALL be accepted.

Verification
REQ-028 a=b=0x3FF0000000000000, zSign=0 -> ap_return 0x4000000000000000, ap_done exactly 4 cycles after accept.
REQ-029 a=0x3FF0000000000000, b=0x3CA0000000000000 (tie) -> 0x3FF0000000000000; b=0x4000000000000000 -> 0x4008000000000000.
REQ-030 a=b=0x7FEFFFFFFFFFFFFF -> 0x7FF0000000000000; a=0x7FF0000000000000, b=0x3FF0000000000000 -> 0x7FF0000000000000.
REQ-031 a=b=0x0000000000000001 -> 0x0000000000000002; a=b=0x000FFFFFFFFFFFFF -> 0x001FFFFFFFFFFFFE.
REQ-032 a=0x7FF0000000000001, b=0x7FF8000000000000 -> 0x7FF8000000000001.
REQ-033 ap_start held high for 12 cycles -> accepts at cycles 0, 5, 10 only; ap_rst asserted in ADD -> no ap_done, ap_return=0.
